// File: rtl/dmem_mmio_bridge_pkg.sv
// Shared constants for the data-memory / MMIO bridge.
// Op codes, memory map, status bit positions and the address decoder.
package dmem_pkg;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  localparam logic [15:0] RAM_BASE  = 16'h0010;
  localparam logic [15:0] MMIO_BASE = 16'h0020;

  localparam logic [15:0] OFF_LED   = 16'h0000;
  localparam logic [15:0] OFF_HEX   = 16'h0004;
  localparam logic [15:0] OFF_SW    = 16'h0008;
  localparam logic [15:0] OFF_KDATA = 16'h0010;
  localparam logic [15:0] OFF_KSTAT = 16'h0014;

  localparam int STAT_NE  = 0;
  localparam int STAT_OVF = 1;
  localparam int STAT_ERR = 2;

  typedef enum logic [2:0] {
    RG_NONE,
    RG_RAM,
    RG_LED,
    RG_HEX,
    RG_SW,
    RG_KDATA,
    RG_KSTAT
  } region_e;

  // MMIO registers decode on the word address so sub-word accesses hit them
  function automatic region_e decode(input logic [31:0] a);
    region_e rg;
    rg = RG_NONE;
    if (a[31:16] == RAM_BASE) begin
      rg = RG_RAM;
    end else if (a[31:16] == MMIO_BASE) begin
      case ({a[15:2], 2'b00})
        OFF_LED:   rg = RG_LED;
        OFF_HEX:   rg = RG_HEX;
        OFF_SW:    rg = RG_SW;
        OFF_KDATA: rg = RG_KDATA;
        OFF_KSTAT: rg = RG_KSTAT;
        default:   rg = RG_NONE;
      endcase
    end
    return rg;
  endfunction

endpackage

// File: rtl/dmem_mmio_bridge_if.sv
// CPU data-memory bus between the MEM stage and the bridge.
// The CPU side is the master; the bridge returns load data.
interface dmem_mmio_bridge_if;
  logic [31:0] dmemaddr;
  logic [31:0] dmemdatain;
  logic [2:0]  dmemop;
  logic        dmemwe;
  logic        dmemre;
  logic [31:0] dmemdataout;

  modport master (
    output dmemaddr,
    output dmemdatain,
    output dmemop,
    output dmemwe,
    output dmemre,
    input  dmemdataout
  );

  modport slave (
    input  dmemaddr,
    input  dmemdatain,
    input  dmemop,
    input  dmemwe,
    input  dmemre,
    output dmemdataout
  );
endinterface

// File: rtl/dmem_mmio_bridge_kbd_fifo.sv
// PS/2 scan-code FIFO; DEPTH must be a power of two, at least 2.
// A pop on empty is ignored; a push while full only lands if a pop frees a slot.
module kbd_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  logic [7:0] i_din,
  input  logic       i_pop,
  output logic       o_full,
  output logic       o_empty,
  output logic [7:0] o_dout
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;

  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wp;
  logic [AW:0] r_rp;
  logic        w_do_pop;
  logic        w_do_push;

  assign o_empty = (r_wp == r_rp);
  assign o_full  = (r_wp[AW] != r_rp[AW]) &&
                   (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign o_dout  = r_mem[r_rp[AW-1:0]];

  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_do_push) r_wp <= r_wp + ONE;
      if (w_do_pop)  r_rp <= r_rp + ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wp[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/dmem_mmio_bridge.sv
// Data RAM + MMIO bridge behind the CPU dmem port, 1-cycle load latency.
// Define DMEM_MMIO_ERR_EN to build the sticky bus_err logic.
module dmem_mmio_bridge
  import dmem_pkg::*;
#(
  parameter int RAM_WORDS = 16384,
  parameter int KBD_DEPTH = 8
) (
  input  logic                CLOCK_50,
  input  logic                rst,
  dmem_mmio_bridge_if.slave   bus,
  input  logic                kbd_valid,
  input  logic [7:0]          kbd_code,
  input  logic [9:0]          sw_in,
  output logic [9:0]          led_out,
  output logic [23:0]         hex_out,
  output logic                bus_err
);

  localparam int IW = $clog2(RAM_WORDS);

  region_e     w_rg;
  logic [1:0]  w_a;
  logic [2:0]  w_op;
  logic        w_we;
  logic        w_re;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [IW-1:0] w_idx;

  assign w_rg  = decode(bus.dmemaddr);
  assign w_a   = bus.dmemaddr[1:0];
  assign w_op  = bus.dmemop;
  assign w_we  = bus.dmemwe;
  assign w_re  = bus.dmemre;
  assign w_idx = bus.dmemaddr[IW+1:2];

  // Misaligned halves/words simply drop the low address bits
  always_comb begin
    w_be    = 4'hf;
    w_wdata = bus.dmemdatain;
    unique case (w_op)
      OP_B, OP_BU: begin
        w_be    = 4'b0001 << w_a;
        w_wdata = {4{bus.dmemdatain[7:0]}};
      end
      OP_H, OP_HU: begin
        w_be    = w_a[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{bus.dmemdatain[15:0]}};
      end
      default: begin
        w_be    = 4'hf;
        w_wdata = bus.dmemdatain;
      end
    endcase
  end

  logic [31:0] r_mem [RAM_WORDS];
  logic [31:0] r_ram_q;

  always_ff @(posedge CLOCK_50) begin
    if (w_we && w_rg == RG_RAM) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
    if (w_re && w_rg == RG_RAM) r_ram_q <= r_mem[w_idx];
  end

  logic       w_pop;
  logic       w_full;
  logic       w_empty;
  logic [7:0] w_kdout;

  assign w_pop = w_re && (w_rg == RG_KDATA);

  kbd_fifo #(.DEPTH(KBD_DEPTH)) u_kbd_fifo (
    .i_clk   (CLOCK_50),
    .i_rst   (rst),
    .i_push  (kbd_valid),
    .i_din   (kbd_code),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_dout  (w_kdout)
  );

  logic r_ovf;
  logic w_ovf_set;
  logic w_stat_wr;

  assign w_ovf_set = kbd_valid & w_full & ~w_pop;
  assign w_stat_wr = w_we && (w_rg == RG_KSTAT);

  always_ff @(posedge CLOCK_50) begin
    if (rst)            r_ovf <= 1'b0;
    else if (w_ovf_set) r_ovf <= 1'b1;
    else if (w_stat_wr) r_ovf <= 1'b0;
  end

  logic w_err;

`ifdef DMEM_MMIO_ERR_EN
  logic r_err;
  logic w_mis;
  logic w_err_set;
  logic w_err_clr;

  always_comb begin
    w_mis = 1'b0;
    if (w_op == OP_H || w_op == OP_HU) w_mis = w_a[0];
    else if (w_op == OP_W)             w_mis = |w_a;
    w_err_set = (w_we | w_re) &
                (w_mis | (w_rg == RG_NONE) |
                 (w_we & (w_rg == RG_SW || w_rg == RG_KDATA)));
    w_err_clr = w_stat_wr & w_wdata[STAT_ERR];
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst)            r_err <= 1'b0;
    else if (w_err_set) r_err <= 1'b1;
    else if (w_err_clr) r_err <= 1'b0;
  end

  assign w_err = r_err;
`else
  assign w_err = 1'b0;
`endif

  logic [31:0] w_stat;
  logic [31:0] w_rword;

  always_comb begin
    w_stat           = '0;
    w_stat[STAT_NE]  = ~w_empty;
    w_stat[STAT_OVF] = r_ovf;
    w_stat[STAT_ERR] = w_err;
  end

  always_comb begin
    w_rword = '0;
    unique case (w_rg)
      RG_LED:   w_rword = {22'b0, led_out};
      RG_HEX:   w_rword = {8'b0, hex_out};
      RG_SW:    w_rword = {22'b0, sw_in};
      RG_KDATA: w_rword = w_empty ? 32'b0 : {24'b0, w_kdout};
      RG_KSTAT: w_rword = w_stat;
      default:  w_rword = '0;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      led_out <= '0;
      hex_out <= '0;
    end else if (w_we) begin
      if (w_rg == RG_LED) led_out <= w_wdata[9:0];
      if (w_rg == RG_HEX) hex_out <= w_wdata[23:0];
    end
  end

  logic        r_pend;
  logic        r_lram;
  logic [1:0]  r_la;
  logic [2:0]  r_lop;
  logic [31:0] r_mword;
  logic [31:0] r_hold;
  logic [31:0] w_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;
  logic [31:0] w_out;

  // r_hold keeps the last result so dmemdataout is stable between loads
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      r_pend  <= 1'b0;
      r_lram  <= 1'b0;
      r_la    <= '0;
      r_lop   <= OP_W;
      r_mword <= '0;
      r_hold  <= '0;
    end else begin
      r_pend <= w_re;
      r_hold <= w_out;
      if (w_re) begin
        r_lram  <= (w_rg == RG_RAM);
        r_la    <= w_a;
        r_lop   <= w_op;
        r_mword <= w_rword;
      end
    end
  end

  assign w_word = r_lram ? r_ram_q : r_mword;
  assign w_byte = w_word[{r_la, 3'b000} +: 8];
  assign w_half = r_la[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_ext = w_word;
    unique case (r_lop)
      OP_B:    w_ext = {{24{w_byte[7]}}, w_byte};
      OP_BU:   w_ext = {24'b0, w_byte};
      OP_H:    w_ext = {{16{w_half[15]}}, w_half};
      OP_HU:   w_ext = {16'b0, w_half};
      default: w_ext = w_word;
    endcase
  end

  assign w_out           = r_pend ? w_ext : r_hold;
  assign bus.dmemdataout = w_out;
  assign bus_err         = w_err;

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Scoreboard bench for dmem_mmio_bridge: loads queue expectations,
// a negedge monitor checks dmemdataout one cycle after each dmemre.
module tb_dmem_mmio_bridge;
  import dmem_pkg::*;

`ifdef DMEM_MMIO_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  localparam logic [31:0] A_LED   = 32'h0020_0000;
  localparam logic [31:0] A_HEX   = 32'h0020_0004;
  localparam logic [31:0] A_SW    = 32'h0020_0008;
  localparam logic [31:0] A_KDATA = 32'h0020_0010;
  localparam logic [31:0] A_KSTAT = 32'h0020_0014;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        kbd_valid = 1'b0;
  logic [7:0]  kbd_code = '0;
  logic [9:0]  sw_in = '0;
  logic [9:0]  led_out;
  logic [23:0] hex_out;
  logic        bus_err;

  always #5 clk = ~clk;

  dmem_mmio_bridge_if bus();

  dmem_mmio_bridge dut (
    .CLOCK_50  (clk),
    .rst       (rst),
    .bus       (bus),
    .kbd_valid (kbd_valid),
    .kbd_code  (kbd_code),
    .sw_in     (sw_in),
    .led_out   (led_out),
    .hex_out   (hex_out),
    .bus_err   (bus_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        re_q = 1'b0;

  always @(posedge clk) re_q <= bus.dmemre && !rst;

  always @(negedge clk) begin : monitor
    logic [31:0] e;
    string       nm;
    if (re_q) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_load: got %08h want none",
                 bus.dmemdataout);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (bus.dmemdataout !== e) begin
          n_bad++;
          $display("FAIL %s: got %08h want %08h",
                   nm, bus.dmemdataout, e);
        end
      end
    end
  end

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", nm, act, exp);
    end
  endtask

  task automatic st(logic [31:0] a, logic [31:0] d, logic [2:0] op);
    bus.dmemaddr   = a;
    bus.dmemdatain = d;
    bus.dmemop     = op;
    bus.dmemwe     = 1'b1;
    @(posedge clk); #1;
    bus.dmemwe     = 1'b0;
  endtask

  task automatic ld(logic [31:0] a, logic [2:0] op,
                    logic [31:0] exp, string nm);
    bus.dmemaddr = a;
    bus.dmemop   = op;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    bus.dmemre   = 1'b1;
    @(posedge clk); #1;
    bus.dmemre   = 1'b0;
  endtask

  task automatic kbd(logic [7:0] c);
    kbd_valid = 1'b1;
    kbd_code  = c;
    @(posedge clk); #1;
    kbd_valid = 1'b0;
  endtask

  initial begin
    bus.dmemaddr   = '0;
    bus.dmemdatain = '0;
    bus.dmemop     = OP_W;
    bus.dmemwe     = 1'b0;
    bus.dmemre     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", bus.dmemdataout, 32'h0);
    check("rst_led", {22'b0, led_out}, 32'h0);
    check("rst_hex", {8'b0, hex_out}, 32'h0);
    check("rst_err", {31'b0, bus_err}, 32'h0);
    rst = 1'b0;

    st(32'h0010_0040, 32'hDEAD_BEEF, OP_W);
    ld(32'h0010_0043, OP_B,  32'hFFFF_FFDE, "lb_43");
    ld(32'h0010_0040, OP_BU, 32'h0000_00EF, "lbu_40");

    st(32'h0010_0040, 32'h1122_3344, OP_W);
    st(32'h0010_0042, 32'h0000_8001, OP_H);
    ld(32'h0010_0040, OP_W,  32'h8001_3344, "lw_after_sh");
    ld(32'h0010_0042, OP_HU, 32'h0000_8001, "lhu_42");
    ld(32'h0010_0042, OP_H,  32'hFFFF_8001, "lh_42");
    repeat (2) @(posedge clk);
    #1;
    check("hold", bus.dmemdataout, 32'hFFFF_8001);
    st(32'h0010_0041, 32'h0000_00A5, OP_B);
    ld(32'h0010_0041, OP_BU, 32'h0000_00A5, "lbu_41");
    ld(32'h0010_0040, OP_H,  32'hFFFF_A544, "lh_40");

    for (int i = 0; i < 9; i++) kbd(8'(8'h10 + i));
    ld(A_KSTAT, OP_W, 32'h3, "stat_full_ovf");
    for (int i = 0; i < 8; i++) ld(A_KDATA, OP_W, 32'(8'h10 + i), "kdata");
    ld(A_KDATA, OP_W, 32'h0, "kdata_empty");
    ld(A_KSTAT, OP_W, 32'h2, "stat_ovf");
    st(A_KSTAT, 32'h0, OP_W);
    ld(A_KSTAT, OP_W, 32'h0, "stat_clr");

    for (int i = 0; i < 8; i++) kbd(8'(8'h20 + i));
    kbd_valid = 1'b1;
    kbd_code  = 8'h55;
    ld(A_KDATA, OP_W, 32'h20, "kdata_pushpop");
    kbd_valid = 1'b0;
    ld(A_KSTAT, OP_W, 32'h1, "stat_no_ovf");
    for (int i = 1; i < 8; i++) ld(A_KDATA, OP_W, 32'(8'h20 + i), "kdata2");
    ld(A_KDATA, OP_W, 32'h55, "kdata_55");
    ld(A_KDATA, OP_W, 32'h0, "kdata_empty2");
    ld(A_KSTAT, OP_W, 32'h0, "stat_empty");

    st(A_LED, 32'h0000_03FF, OP_W);
    st(A_HEX, 32'h0012_3456, OP_W);
    check("led_out", {22'b0, led_out}, 32'h3FF);
    check("hex_out", {8'b0, hex_out}, 32'h12_3456);
    ld(A_LED, OP_W, 32'h3FF, "led_rd");
    ld(A_HEX, OP_W, 32'h12_3456, "hex_rd");
    sw_in = 10'h2A5;
    ld(A_SW, OP_W, 32'h2A5, "sw_rd");
    st(32'h0020_0001, 32'h0000_005A, OP_B);
    check("led_sb", {22'b0, led_out}, 32'h25A);

    st(A_SW, 32'h0, OP_W);
    check("err_sw_store", {31'b0, bus_err}, {31'b0, ERR});
    ld(A_SW, OP_W, 32'h2A5, "sw_unchanged");
    st(A_KSTAT, 32'h4, OP_W);
    check("err_clr1", {31'b0, bus_err}, 32'h0);
    ld(32'h0030_0000, OP_W, 32'h0, "unmapped_rd");
    check("err_unmapped", {31'b0, bus_err}, {31'b0, ERR});
    st(A_KSTAT, 32'h4, OP_W);
    ld(32'h0010_0042, OP_W, 32'h8001_A544, "lw_misaligned");
    check("err_misalign", {31'b0, bus_err}, {31'b0, ERR});
    ld(A_KSTAT, OP_W, ERR ? 32'h4 : 32'h0, "stat_err_bit");
    st(A_KSTAT, 32'h4, OP_W);
    check("err_clr2", {31'b0, bus_err}, 32'h0);

    ld(A_LED, OP_W, 32'h25A, "led_pre_rst");
    st(A_SW, 32'h0, OP_W);
    check("pre_rst_dout", bus.dmemdataout, 32'h25A);
    bus.dmemaddr = A_LED;
    bus.dmemop   = OP_W;
    bus.dmemre   = 1'b1;
    rst          = 1'b1;
    @(posedge clk); #1;
    bus.dmemre   = 1'b0;
    rst          = 1'b0;
    check("rst_mid_dout", bus.dmemdataout, 32'h0);
    check("rst_mid_err", {31'b0, bus_err}, 32'h0);
    check("rst_mid_led", {22'b0, led_out}, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
